// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, field slices, NOP and reset PC.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   localparam int OPC_MSB  = 31;
   localparam int OPC_LSB  = 26;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;
   localparam int IMM_MSB  = 15;
   localparam int IMM_LSB  = 0;
   localparam int JIDX_MSB = 25;
   localparam int JIDX_LSB = 0;

   // Word-scaled, sign-extended branch displacement.
   function automatic logic [31:0] branch_offset(input logic [31:0] word);
      logic [15:0] imm;
      imm = word[IMM_MSB:IMM_LSB];
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC select: jump over taken branch over sequential.
module instr_fetch_next_pc
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [31:0] instr,
   input  logic        jump,
   input  logic        branch,
   input  logic        branch_taken,
   output logic [31:0] next_pc
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;

   always_comb begin
      jump_target   = {pc_plus4[31:28], instr[JIDX_MSB:JIDX_LSB], 2'b00};
      branch_target = pc_plus4 + branch_offset(instr);
      if (jump) begin
         next_pc = jump_target;
      end else if (branch && branch_taken) begin
         next_pc = branch_target;
      end else begin
         next_pc = pc_plus4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, imem req/ready handshake, instruction register, next-PC resolve on ack.
// Optional MIPS delay slot behaviour under INSTR_FETCH_DELAY_SLOT_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic [5:0]  funct,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        instr_ack,
   input  logic        jump,
   input  logic        branch,
   input  logic        branch_taken
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         req_q, req_d;
   logic         valid_q, valid_d;
   logic [31:0]  next_pc;

`ifdef INSTR_FETCH_DELAY_SLOT_EN
   logic         pend_q, pend_d;
   logic [31:0]  pend_target_q, pend_target_d;
   logic         redirect;
   assign redirect = jump | (branch & branch_taken);
`endif

   assign pc_plus4 = pc_q + 32'd4;

   instr_fetch_next_pc u_next_pc (
      .pc_plus4     (pc_plus4),
      .instr        (instr_q),
      .jump         (jump),
      .branch       (branch),
      .branch_taken (branch_taken),
      .next_pc      (next_pc)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      req_d   = req_q;
      valid_d = valid_q;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
      pend_d        = pend_q;
      pend_target_d = pend_target_q;
`endif
      case (state_q)
         BOOT: begin
            state_d = FETCH;
            req_d   = 1'b1;
         end
         FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (instr_ack) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = FETCH;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
               // The delay-slot instruction's own control inputs are ignored.
               if (pend_q) begin
                  pc_d   = pend_target_q;
                  pend_d = 1'b0;
               end else if (redirect) begin
                  pend_target_d = next_pc;
                  pend_d        = 1'b1;
                  pc_d          = pc_plus4;
               end else begin
                  pc_d = pc_plus4;
               end
`else
               pc_d = next_pc;
`endif
            end
         end
         default: begin
            state_d = BOOT;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
         pend_q        <= 1'b0;
         pend_target_q <= 32'h0000_0000;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
`ifdef INSTR_FETCH_DELAY_SLOT_EN
         pend_q        <= pend_d;
         pend_target_q <= pend_target_d;
`endif
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[OPC_MSB:OPC_LSB];
   assign funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
   assign pc          = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetch/issue records plus wait-state and reset sequences.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_ack;
   logic        jump;
   logic        branch;
   logic        branch_taken;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .opcode       (opcode),
      .funct        (funct),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .instr_ack    (instr_ack),
      .jump         (jump),
      .branch       (branch),
      .branch_taken (branch_taken)
   );

   typedef struct {
      logic [31:0] word;
      logic        j;
      logic        b;
      logic        t;
      logic [31:0] exp_pc;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] w, input logic j, input logic b,
                               input logic t, input logic [31:0] p, input logic [31:0] n);
      vec_t v;
      v.word = w; v.j = j; v.b = b; v.t = t; v.exp_pc = p; v.exp_next = n;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ctrl(input logic a, input logic j, input logic b, input logic t);
      instr_ack = a; jump = j; branch = b; branch_taken = t;
   endtask

   // One FETCH (zero wait) + ISSUE (immediate ack) transaction.
   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] w;
      w = v.word;
      check($sformatf("v%0d req", idx), {31'd0, imem_req}, 32'd1);
      check($sformatf("v%0d addr", idx), imem_addr, v.exp_pc);
      check($sformatf("v%0d valid_pre", idx), {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      imem_rdata = w;
      step();
      imem_ready = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      check($sformatf("v%0d valid", idx), {31'd0, instr_valid}, 32'd1);
      check($sformatf("v%0d req_low", idx), {31'd0, imem_req}, 32'd0);
      check($sformatf("v%0d instr", idx), instr, w);
      check($sformatf("v%0d opcode", idx), {26'd0, opcode}, {26'd0, w[31:26]});
      check($sformatf("v%0d funct", idx), {26'd0, funct}, {26'd0, w[5:0]});
      check($sformatf("v%0d pc", idx), pc, v.exp_pc);
      check($sformatf("v%0d pc_plus4", idx), pc_plus4, v.exp_pc + 32'd4);
      drive_ctrl(1'b1, v.j, v.b, v.t);
      step();
      drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d next_pc", idx), pc, v.exp_next);
      check($sformatf("v%0d valid_post", idx), {31'd0, instr_valid}, 32'd0);
      $display("vec %0d word=%h j=%0d b=%0d t=%0d pc=%h -> next=%h (exp %h)",
               idx, w, v.j, v.b, v.t, v.exp_pc, pc, v.exp_next);
   endtask

   logic [31:0] cur_pc;
   logic [31:0] held_word;

   initial begin
      rst_n = 1'b0;
      imem_ready = 1'b0;
      imem_rdata = 32'h0;
      drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef INSTR_FETCH_DELAY_SLOT_EN
      vecs.push_back(mk(32'h0000_0020, 0, 0, 0, 32'h0000_3000, 32'h0000_3004));
      vecs.push_back(mk(32'h8C00_0004, 0, 0, 0, 32'h0000_3004, 32'h0000_3008));
      vecs.push_back(mk(32'h0000_0022, 0, 0, 0, 32'h0000_3008, 32'h0000_300C));
      vecs.push_back(mk(32'h0000_0024, 0, 0, 0, 32'h0000_300C, 32'h0000_3010));
      vecs.push_back(mk(32'h1000_FFFC, 0, 1, 0, 32'h0000_3010, 32'h0000_3014));
      vecs.push_back(mk(32'h0000_0025, 0, 0, 0, 32'h0000_3014, 32'h0000_3018));
      vecs.push_back(mk(32'h0000_0026, 0, 0, 0, 32'h0000_3018, 32'h0000_301C));
      vecs.push_back(mk(32'h0000_0027, 0, 0, 0, 32'h0000_301C, 32'h0000_3020));
      vecs.push_back(mk(32'h0800_0C10, 1, 1, 1, 32'h0000_3020, 32'h0000_3024));
      // Delay-slot instruction: its own jump is ignored, pending target wins.
      vecs.push_back(mk(32'h0800_0000, 1, 0, 0, 32'h0000_3024, 32'h0000_3040));
      vecs.push_back(mk(32'h0000_002A, 0, 0, 0, 32'h0000_3040, 32'h0000_3044));
`else
      vecs.push_back(mk(32'h0000_0020, 0, 0, 0, 32'h0000_3000, 32'h0000_3004));
      vecs.push_back(mk(32'h8C00_0004, 0, 0, 0, 32'h0000_3004, 32'h0000_3008));
      vecs.push_back(mk(32'h0000_0022, 0, 0, 0, 32'h0000_3008, 32'h0000_300C));
      vecs.push_back(mk(32'h0000_0024, 0, 0, 0, 32'h0000_300C, 32'h0000_3010));
      vecs.push_back(mk(32'h1000_FFFC, 0, 1, 1, 32'h0000_3010, 32'h0000_3004));
      vecs.push_back(mk(32'h8C00_0008, 0, 0, 0, 32'h0000_3004, 32'h0000_3008));
      vecs.push_back(mk(32'h0000_0022, 0, 0, 0, 32'h0000_3008, 32'h0000_300C));
      vecs.push_back(mk(32'h0000_0024, 0, 0, 0, 32'h0000_300C, 32'h0000_3010));
      vecs.push_back(mk(32'h1000_FFFC, 0, 1, 0, 32'h0000_3010, 32'h0000_3014));
      vecs.push_back(mk(32'h0000_0025, 0, 0, 0, 32'h0000_3014, 32'h0000_3018));
      vecs.push_back(mk(32'h0000_0026, 0, 0, 0, 32'h0000_3018, 32'h0000_301C));
      vecs.push_back(mk(32'h0000_0027, 0, 0, 0, 32'h0000_301C, 32'h0000_3020));
      vecs.push_back(mk(32'h0800_0C10, 1, 1, 1, 32'h0000_3020, 32'h0000_3040));
      // Largest negative displacement: 0x3044 - 0x20000 wraps below zero.
      vecs.push_back(mk(32'h1000_8000, 0, 1, 1, 32'h0000_3040, 32'hFFFE_3044));
      vecs.push_back(mk(32'h0BFF_FFFF, 1, 0, 0, 32'hFFFE_3044, 32'hFFFF_FFFC));
      vecs.push_back(mk(32'h0000_0021, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000));
`endif

      // Reset held for three cycles.
      repeat (3) step();
      check("rst pc", pc, 32'h0000_3000);
      check("rst valid", {31'd0, instr_valid}, 32'd0);
      check("rst req", {31'd0, imem_req}, 32'd0);
      check("rst instr", instr, 32'h0000_0000);
      rst_n = 1'b1;
      check("boot req", {31'd0, imem_req}, 32'd0);
      step();
      check("fetch req", {31'd0, imem_req}, 32'd1);
      check("fetch addr", imem_addr, 32'h0000_3000);
      $display("reset sequence done pc=%h req=%0d", pc, imem_req);

      foreach (vecs[i]) run_vec(vecs[i], i);
      cur_pc = vecs[vecs.size()-1].exp_next;

      // Memory wait states; control inputs must be ignored during FETCH.
      drive_ctrl(1'b1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("wait%0d addr", k), imem_addr, cur_pc);
         check($sformatf("wait%0d valid", k), {31'd0, instr_valid}, 32'd0);
         check($sformatf("wait%0d req", k), {31'd0, imem_req}, 32'd1);
      end
      drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
      held_word = 32'h2108_0001;
      imem_ready = 1'b1;
      imem_rdata = held_word;
      step();
      check("wait valid", {31'd0, instr_valid}, 32'd1);
      check("wait instr", instr, held_word);
      $display("wait-state fetch pc=%h instr=%h", pc, instr);

      // Ack withheld; further imem_ready is ignored outside FETCH.
      imem_rdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("hold%0d instr", k), instr, held_word);
         check($sformatf("hold%0d pc", k), pc, cur_pc);
         check($sformatf("hold%0d valid", k), {31'd0, instr_valid}, 32'd1);
      end
      imem_ready = 1'b0;
      drive_ctrl(1'b1, 1'b0, 1'b0, 1'b0);
      step();
      drive_ctrl(1'b0, 1'b0, 1'b0, 1'b0);
      check("hold next_pc", pc, cur_pc + 32'd4);
      check("hold req", {31'd0, imem_req}, 32'd1);
      $display("ack after hold pc=%h", pc);

      // Reset mid-FETCH with a late imem_ready.
      step();
      rst_n = 1'b0;
      step();
      imem_ready = 1'b1;
      imem_rdata = 32'h1234_5678;
      check("mrst req", {31'd0, imem_req}, 32'd0);
      check("mrst pc", pc, 32'h0000_3000);
      step();
      check("mrst valid", {31'd0, instr_valid}, 32'd0);
      check("mrst instr", instr, 32'h0000_0000);
      rst_n = 1'b1;
      step();
      imem_ready = 1'b0;
      check("mrst boot valid", {31'd0, instr_valid}, 32'd0);
      check("mrst boot req", {31'd0, imem_req}, 32'd1);
      check("mrst boot addr", imem_addr, 32'h0000_3000);
      $display("mid-fetch reset done pc=%h valid=%0d", pc, instr_valid);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
